// File: rtl/scan_pkg.sv
// Shared types and helpers for the serial configuration scan controller.
package scan_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    MODE,
    WDATA,
    RDATA
  } scan_state_e;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  // Bits needed to hold any count in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/scan_shreg.sv
// Shift register with parallel load, shift-left serial input and MSB serial output.
module scan_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_en,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         ser_in,
  output logic [W-1:0] q,
  output logic         msb
);

  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_en) begin
      sr_d = load_data;
    end else if (shift_en) begin
      // Truncating cast drops the old MSB and keeps the widths legal for W=1.
      sr_d = W'({sr_q, ser_in});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q   = sr_q;
  assign msb = sr_q[W-1];

endmodule

// File: rtl/scan_ctrl.sv
// Serial scan frame decoder: address, mode bit, then write payload or read stream.
module scan_ctrl
  import scan_pkg::*;
#(
  parameter int N_CHAINS = 3,
  parameter int DATA_W   = 169,
  parameter int ADDR_W   = 12
) (
  input  logic                         scan_clk,
  input  logic                         reset,
  input  logic                         scan_en,
  input  logic                         scan_in,
  output logic                         scan_out,
  input  logic [N_CHAINS*DATA_W-1:0]   rd_data,
  output logic [DATA_W-1:0]            cfg_data,
  output logic [N_CHAINS-1:0]          cfg_load,
  output logic                         frame_err,
  output logic                         busy
);

  localparam int CNT_MAX = (ADDR_W > DATA_W + 1) ? ADDR_W : DATA_W + 1;
  localparam int CW      = cnt_width(CNT_MAX);

  localparam logic [CW-1:0]   ADDR_LAST = CW'(ADDR_W - 1);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(DATA_W);
  localparam logic [CW-1:0]   CNT_SAT   = CW'(DATA_W + 1);
  localparam logic [ADDR_W:0] N_CH      = (ADDR_W + 1)'(N_CHAINS);

  scan_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0]    cfg_data_q, cfg_data_d;
  logic [N_CHAINS-1:0]  cfg_load_q, cfg_load_d;
  logic                 err_q, err_d;

  logic                 sr_load;
  logic                 sr_shift;
  logic [DATA_W-1:0]    sr_load_data;
  logic [DATA_W-1:0]    sr_val;
  logic                 sr_msb;

  logic [DATA_W-1:0]    rd_slice [N_CHAINS];
  logic [N_CHAINS-1:0]  addr_hit;
  logic [DATA_W-1:0]    rd_sel;
  logic                 addr_valid;

  // Zero-extended compare so out-of-range addresses never alias onto a chain.
  assign addr_valid = ({1'b0, addr_q} < N_CH);

  generate
    for (genvar gi = 0; gi < N_CHAINS; gi++) begin : g_chain
      assign rd_slice[gi] = rd_data[gi*DATA_W +: DATA_W];
      assign addr_hit[gi] = ({1'b0, addr_q} == (ADDR_W + 1)'(gi));
    end
  endgenerate

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < N_CHAINS; k++) begin
      if (addr_hit[k]) begin
        rd_sel = rd_slice[k];
      end
    end
  end

  assign sr_load_data = addr_valid ? rd_sel : '0;

  scan_shreg #(
    .W (DATA_W)
  ) u_shreg (
    .clk       (scan_clk),
    .reset     (reset),
    .load_en   (sr_load),
    .load_data (sr_load_data),
    .shift_en  (sr_shift),
    .ser_in    (scan_in),
    .q         (sr_val),
    .msb       (sr_msb)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    cfg_data_d = cfg_data_q;
    cfg_load_d = '0;
    err_d      = err_q;
    sr_load    = 1'b0;
    sr_shift   = 1'b0;

    case (state_q)
      IDLE: begin
        if (scan_en) begin
          addr_d  = ADDR_W'({addr_q, scan_in});
          cnt_d   = CW'(1);
          state_d = (ADDR_W == 1) ? MODE : ADDR;
        end
      end

      ADDR: begin
        if (!scan_en) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          addr_d = ADDR_W'({addr_q, scan_in});
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == ADDR_LAST) begin
            state_d = MODE;
          end
        end
      end

      MODE: begin
        if (!scan_en) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (scan_in == MODE_WRITE) begin
          cnt_d   = '0;
          state_d = WDATA;
        end else begin
          sr_load = 1'b1;
          state_d = RDATA;
        end
      end

      WDATA: begin
        if (scan_en) begin
          sr_shift = 1'b1;
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          // Commit only an exact-length payload to an existing chain.
          if ((cnt_q == CNT_FULL) && addr_valid) begin
            cfg_data_d = sr_val;
            cfg_load_d = addr_hit;
            err_d      = 1'b0;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      end

      RDATA: begin
        if (scan_en) begin
          sr_shift = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge scan_clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      cfg_data_q <= '0;
      cfg_load_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      cfg_data_q <= cfg_data_d;
      cfg_load_q <= cfg_load_d;
      err_q      <= err_d;
    end
  end

  assign scan_out  = (state_q == RDATA) && sr_msb;
  assign busy      = (state_q != IDLE);
  assign cfg_data  = cfg_data_q;
  assign cfg_load  = cfg_load_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_scan_ctrl.sv
// Directed plus randomized frames against a transaction-level model of the scan protocol.
module tb_scan_ctrl;

  localparam int N_CHAINS = 3;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 4;

  logic                        scan_clk = 1'b0;
  logic                        reset;
  logic                        scan_en;
  logic                        scan_in;
  logic                        scan_out;
  logic [N_CHAINS*DATA_W-1:0]  rd_data;
  logic [DATA_W-1:0]           cfg_data;
  logic [N_CHAINS-1:0]         cfg_load;
  logic                        frame_err;
  logic                        busy;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_cfg_data = 8'h00;
  logic       m_err      = 1'b0;

  scan_ctrl #(
    .N_CHAINS (N_CHAINS),
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .scan_clk  (scan_clk),
    .reset     (reset),
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .scan_out  (scan_out),
    .rd_data   (rd_data),
    .cfg_data  (cfg_data),
    .cfg_load  (cfg_load),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 scan_clk = ~scan_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge scan_clk);
    @(negedge scan_clk);
  endtask

  task automatic in_frame(input string tag, input bit chk_out);
    chk({tag, "_load_idle"}, 32'(cfg_load), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    if (chk_out) chk({tag, "_out_quiet"}, 32'(scan_out), 32'd0);
  endtask

  task automatic send_addr(input logic [3:0] a, input string tag);
    for (int i = 3; i >= 0; i--) begin
      scan_en = 1'b1;
      scan_in = a[i];
      tick();
      in_frame(tag, 1'b1);
    end
  endtask

  task automatic write_frame(input logic [3:0] a, input int n, input logic [15:0] d);
    bit         ok;
    logic [2:0] e_load;
    send_addr(a, "wr");
    scan_in = 1'b1;
    tick();
    in_frame("wr_mode", 1'b1);
    for (int i = n - 1; i >= 0; i--) begin
      scan_in = d[i];
      tick();
      in_frame("wr_data", 1'b1);
    end
    scan_en = 1'b0;
    scan_in = 1'($urandom);
    tick();
    ok     = (n == DATA_W) && (a < N_CHAINS);
    e_load = '0;
    if (ok) begin
      e_load[a[1:0]] = 1'b1;
      m_cfg_data     = d[7:0];
      m_err          = 1'b0;
    end else begin
      m_err = 1'b1;
    end
    chk("wr_cfg_load", 32'(cfg_load), 32'(e_load));
    chk("wr_cfg_data", 32'(cfg_data), 32'(m_cfg_data));
    chk("wr_frame_err", 32'(frame_err), 32'(m_err));
    chk("wr_busy_end", 32'(busy), 32'd0);
    $display("write addr=%0d bits=%0d data=%0h -> load=%b cfg_data=%0h err=%0b",
             a, n, d, cfg_load, cfg_data, frame_err);
  endtask

  task automatic read_frame(input logic [3:0] a, input int n, input logic [23:0] rd);
    logic       q[$];
    logic [7:0] sl;
    rd_data = rd;
    sl = (a < N_CHAINS) ? rd[int'(a)*8 +: 8] : 8'h00;
    for (int i = 7; i >= 0; i--) q.push_back(sl[i]);
    send_addr(a, "rd");
    scan_in = 1'b0;
    tick();
    in_frame("rd_mode", 1'b0);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("rd_bit%0d", i), 32'(scan_out), 32'(q[i]));
      scan_in = 1'($urandom);
      q.push_back(scan_in);
      tick();
      chk("rd_load_idle", 32'(cfg_load), 32'd0);
    end
    scan_en = 1'b0;
    tick();
    chk("rd_out_after", 32'(scan_out), 32'd0);
    chk("rd_busy_end", 32'(busy), 32'd0);
    chk("rd_frame_err", 32'(frame_err), 32'(m_err));
    chk("rd_load_end", 32'(cfg_load), 32'd0);
    $display("read  addr=%0d bits=%0d slice=%0h err=%0b", a, n, sl, frame_err);
  endtask

  task automatic abort_frame(input logic [3:0] a, input int k);
    for (int i = 0; i < k; i++) begin
      scan_en = 1'b1;
      scan_in = a[3 - i];
      tick();
      in_frame("ab", 1'b1);
    end
    scan_en = 1'b0;
    tick();
    m_err = 1'b1;
    chk("ab_frame_err", 32'(frame_err), 32'd1);
    chk("ab_busy_end", 32'(busy), 32'd0);
    chk("ab_load", 32'(cfg_load), 32'd0);
    $display("abort addr=%0d after %0d header bits -> err=%0b", a, k, frame_err);
  endtask

  task automatic reset_mid_write(input logic [3:0] a, input logic [2:0] d);
    send_addr(a, "rs");
    scan_in = 1'b1;
    tick();
    for (int i = 2; i >= 0; i--) begin
      scan_in = d[i];
      tick();
    end
    #2 reset = 1'b1;
    #1;
    chk("rs_async_busy", 32'(busy), 32'd0);
    scan_en = 1'b0;
    @(posedge scan_clk);
    #1;
    chk("rs_load", 32'(cfg_load), 32'd0);
    chk("rs_cfg_data", 32'(cfg_data), 32'd0);
    chk("rs_frame_err", 32'(frame_err), 32'd0);
    chk("rs_out", 32'(scan_out), 32'd0);
    @(negedge scan_clk);
    reset      = 1'b0;
    m_cfg_data = 8'h00;
    m_err      = 1'b0;
    tick();
    chk("rs_load_after", 32'(cfg_load), 32'd0);
    chk("rs_busy_after", 32'(busy), 32'd0);
    $display("reset mid-write addr=%0d -> load=%b cfg_data=%0h busy=%0b", a, cfg_load, cfg_data, busy);
  endtask

  initial begin
    int         kind;
    logic [3:0] ra;
    int         rn;
    reset   = 1'b1;
    scan_en = 1'b0;
    scan_in = 1'b0;
    rd_data = '0;
    @(negedge scan_clk);
    @(negedge scan_clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_load", 32'(cfg_load), 32'd0);
    chk("rst_cfg_data", 32'(cfg_data), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_out", 32'(scan_out), 32'd0);
    reset = 1'b0;
    tick();

    write_frame(4'd2, 8, 16'h00A5);
    tick();
    chk("pulse_one_cycle", 32'(cfg_load), 32'd0);
    read_frame(4'd1, 8, 24'h00_3C_00);
    write_frame(4'd0, 7, 16'h0055);
    write_frame(4'd0, 8, 16'h0011);
    write_frame(4'd5, 8, 16'h00FF);
    read_frame(4'd5, 8, 24'hFF_FF_FF);
    reset_mid_write(4'd1, 3'b101);
    write_frame(4'd1, 8, 16'h005A);
    write_frame(4'd1, 8, 16'h00C3);
    write_frame(4'd2, 8, 16'h003E);
    write_frame(4'd0, 9, 16'h01F0);
    abort_frame(4'd3, 2);
    abort_frame(4'd1, 4);
    read_frame(4'd15, 4, 24'hAB_CD_EF);

    for (int it = 0; it < 30; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0, 1: begin
          ra = ($urandom_range(0, 4) != 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(3, 15));
          rn = ($urandom_range(0, 3) != 0) ? 8 : $urandom_range(6, 10);
          write_frame(ra, rn, 16'($urandom));
        end
        2: read_frame(4'($urandom_range(0, 5)), $urandom_range(1, 12), 24'($urandom));
        default: abort_frame(4'($urandom), $urandom_range(1, 4));
      endcase
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_ctrl.md
SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter N_CHAINS, default 3: number of addressable configuration chains.
REQ-002 Parameter DATA_W, default 169: payload bits per chain.
REQ-003 Parameter ADDR_W, default 12: address field bits.
REQ-004 scan_clk  in  1  scan clock; all state changes on posedge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 scan_en  in  1  frame enable; high for the whole transaction.
REQ-007 scan_in  in  1  serial input, MSB first.
REQ-008 scan_out  out  1  serial read data, MSB first.
REQ-009 rd_data  in  N_CHAINS*DATA_W  readback bus; chain k occupies bits [k*DATA_W +: DATA_W].
REQ-010 cfg_data  out  DATA_W  last committed write payload, shared by all chains.
REQ-011 cfg_load  out  N_CHAINS  one-hot single-cycle load strobe; chain registers capture cfg_data while their bit is high.
REQ-012 frame_err  out  1  sticky protocol-error flag.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 States SHALL be IDLE, ADDR, MODE, WDATA, RDATA.
REQ-015 IDLE, scan_en=1: shift scan_in into addr MSB; count=1; go to ADDR (go to MODE if ADDR_W=1).
REQ-016 ADDR: shift one address bit per cycle; go to MODE after the ADDR_W-th bit is captured.
REQ-017 MODE: sample mode bit; 1 -> WDATA with bit count 0; 0 -> RDATA, loading the shift register with the rd_data slice for addr, or all zeros if addr >= N_CHAINS.
REQ-018 WDATA: shift scan_in into the shift register LSB each cycle; the bit count saturates at DATA_W+1.
REQ-019 WDATA, scan_en sampled 0, count == DATA_W and addr < N_CHAINS: cfg_data <= shift register; cfg_load <= one-hot(addr); frame_err <= 0; go to IDLE.
REQ-020 WDATA, scan_en sampled 0, count != DATA_W or addr >= N_CHAINS: no load; frame_err <= 1; go to IDLE.
REQ-021 cfg_load SHALL be high for exactly one scan_clk cycle, then return to zero.
REQ-022 RDATA: scan_out = shift register MSB; shift left each cycle, filling with scan_in, so the host reads bit DATA_W-1 at the first posedge after MODE.
REQ-023 RDATA, scan_en sampled 0: go to IDLE; no load and no error, for any frame length.
REQ-024 scan_out SHALL be 0 in every state other than RDATA.
REQ-025 scan_en sampled 0 in ADDR or MODE: frame_err <= 1; go to IDLE.
REQ-026 A frame may start on the cycle immediately after a commit; the falling cfg_load and the new frame's first address bit are independent.
REQ-027 The address compare SHALL be unsigned over the full ADDR_W bits; no aliasing.

Reset
REQ-028 reset=1: state=IDLE; address, count, shift register and cfg_data are 0; cfg_load=0; frame_err=0; busy=0; scan_out=0.
REQ-029 reset asserted mid-frame SHALL abort the frame without a cfg_load pulse; the next frame starts from IDLE.

Structure
REQ-030 Shared package scan_pkg SHALL hold the state enum, the MODE_READ/MODE_WRITE encodings and a clog2-based count-width helper.
REQ-031 The DATA_W shift register with parallel load and serial in/out SHALL be the sub-module scan_shreg.
REQ-032 Chain storage registers and their reset values SHALL live outside scan_ctrl.

Verification (bench parameters: N_CHAINS=3, DATA_W=8, ADDR_W=4)
REQ-033 Write, address 4'd2, mode 1, payload 0xA5, then scan_en low -> cfg_load=3'b100 for one cycle, cfg_data=0xA5, frame_err=0.
REQ-034 Read, address 4'd1, rd_data slice 1 = 0x3C -> scan_out over 8 cycles = 0,0,1,1,1,1,0,0; cfg_load stays 0.
REQ-035 Write, address 0, only 7 payload bits -> no cfg_load, frame_err=1; a following valid write of 0x11 to address 0 -> cfg_load=3'b001, frame_err=0.
REQ-036 Write, address 4'd5, 8 bits -> no cfg_load, frame_err=1; read of address 5 -> scan_out all 0.
REQ-037 reset pulsed after 3 payload bits of a write -> cfg_load never asserts, cfg_data=0, busy=0; the next write succeeds.
REQ-038 Back-to-back writes, the second starting the cycle after the first commit -> two separate cfg_load pulses carrying the correct data.
